// File: rtl/lcd_ctrl_pkg.sv
// Shared constants for the LCD controller: command codes, FSM states,
// operation-point limits and the window pixel index helper.
package lcd_ctrl_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_AVG   = 3'd5;
  localparam logic [2:0] CMD_MIRX  = 3'd6;
  localparam logic [2:0] CMD_MIRY  = 3'd7;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_AVG   = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  localparam logic [2:0] PT_MIN = 3'd2;
  localparam logic [2:0] PT_MAX = 3'd6;
  localparam logic [2:0] PT_RST = 3'd4;
  localparam int         WIN    = 4;
  localparam int         NPIX   = 64;

  // Frame index of window cell (r,c); the window's top-left is (py-2, px-2).
  function automatic logic [5:0] win_idx(input logic [2:0] px, input logic [2:0] py,
                                         input logic [1:0] r, input logic [1:0] c);
    logic [2:0] row, col;
    row = py - 3'd2 + {1'b0, r};
    col = px - 3'd2 + {1'b0, c};
    return {row, col};
  endfunction

endpackage

// File: rtl/lcd_win_avg.sv
// Window accumulator: sums 16 pixels into a 12-bit register and presents
// the floor average (sum >> 4).
module lcd_win_avg #(
  parameter int PIX_W = 8,
  parameter int SUM_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_acc,
  input  logic [PIX_W-1:0] i_pix,
  output logic [PIX_W-1:0] o_avg
);

  logic [SUM_W-1:0] r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_sum <= '0;
    else if (i_clr) r_sum <= '0;
    else if (i_acc) r_sum <= r_sum + SUM_W'(i_pix);
  end

  assign o_avg = PIX_W'(r_sum[SUM_W-1:4]);

endmodule

// File: rtl/lcd_ctrl.sv
// LCD controller top: frame load from IROM, window commands, frame write to IRAM.
// Define LCD_CTRL_MIRROR_EN to enable the MIRROR_X / MIRROR_Y commands.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  input  logic [PIX_W-1:0]  IROM_Q,
  output logic              IROM_EN,
  output logic [ADDR_W-1:0] IROM_A,
  output logic              busy,
  output logic              done,
  output logic              IRAM_valid,
  output logic [PIX_W-1:0]  IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  state_e            r_state;
  logic [2:0]        r_cmd, r_px, r_py;
  logic [4:0]        r_cnt;
  logic              r_ld_go, r_cap_vld;
  logic [ADDR_W-1:0] r_cap_idx;
  logic [PIX_W-1:0]  r_buf [NPIX];

  logic [PIX_W-1:0]  w_avg_pix, w_avg;
  logic              w_acc, w_clr;

  assign w_avg_pix = r_buf[win_idx(r_px, r_py, r_cnt[3:2], r_cnt[1:0])];
  assign w_acc     = (r_state == ST_AVG) && !r_cnt[4];
  assign w_clr     = (r_state == ST_EXEC);

  lcd_win_avg #(.PIX_W(PIX_W)) u_avg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_acc   (w_acc),
    .i_pix   (w_avg_pix),
    .o_avg   (w_avg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_LOAD;
      busy       <= 1'b1;
      done       <= 1'b0;
      IROM_EN    <= 1'b1;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_D     <= '0;
      IRAM_A     <= '0;
      r_cmd      <= '0;
      r_px       <= PT_RST;
      r_py       <= PT_RST;
      r_cnt      <= '0;
      r_ld_go    <= 1'b0;
      r_cap_vld  <= 1'b0;
      r_cap_idx  <= '0;
      for (int i = 0; i < NPIX; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          // ROM data for the address sampled last edge lands one edge later
          r_cap_vld <= 1'b0;
          if (!r_ld_go) begin
            r_ld_go <= 1'b1;
            IROM_EN <= 1'b0;
          end else if (!IROM_EN) begin
            r_cap_vld <= 1'b1;
            r_cap_idx <= IROM_A;
            if (IROM_A == LAST) IROM_EN <= 1'b1;
            else                IROM_A  <= IROM_A + 1'b1;
          end
          if (r_cap_vld) begin
            r_buf[r_cap_idx] <= IROM_Q;
            if (r_cap_idx == LAST) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cmd   <= cmd;
            r_state <= ST_EXEC;
            busy    <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          case (r_cmd)
            CMD_WRITE: begin
              r_state    <= ST_WRITE;
              busy       <= 1'b1;
              IRAM_valid <= 1'b1;
              IRAM_A     <= '0;
              IRAM_D     <= r_buf[0];
            end
            CMD_UP:    if (r_py > PT_MIN) r_py <= r_py - 3'd1;
            CMD_DOWN:  if (r_py < PT_MAX) r_py <= r_py + 3'd1;
            CMD_LEFT:  if (r_px > PT_MIN) r_px <= r_px - 3'd1;
            CMD_RIGHT: if (r_px < PT_MAX) r_px <= r_px + 3'd1;
            CMD_AVG: begin
              r_state <= ST_AVG;
              busy    <= 1'b1;
              r_cnt   <= '0;
            end
`ifdef LCD_CTRL_MIRROR_EN
            CMD_MIRX:
              for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                  r_buf[win_idx(r_px, r_py, 2'(r), 2'(c))] <=
                    r_buf[win_idx(r_px, r_py, 2'(3 - r), 2'(c))];
            CMD_MIRY:
              for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                  r_buf[win_idx(r_px, r_py, 2'(r), 2'(c))] <=
                    r_buf[win_idx(r_px, r_py, 2'(r), 2'(3 - c))];
`endif
            default: ;
          endcase
        end
        ST_AVG: begin
          if (r_cnt == 5'd16) begin
            for (int k = 0; k < WIN * WIN; k++)
              r_buf[win_idx(r_px, r_py, 2'(k >> 2), 2'(k))] <= w_avg;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_WRITE: begin
          if (done) begin
            done    <= 1'b0;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (IRAM_A == LAST) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
          end else begin
            IRAM_A <= IRAM_A + 1'b1;
            IRAM_D <= r_buf[IRAM_A + 1'b1];
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Image display controller consuming the 64×8-bit image ROM (`IROM`). After reset it loads the whole 8×8 frame into an internal pixel buffer, then executes host commands on a 4×4 operation window: shift, average, mirror. On a write command it streams the processed frame to the downstream image RAM.

## Interface
- `ADDR_W`, default 6: IROM/IRAM address width (64 pixels).
- `PIX_W`, default 8: pixel width.
- `clk` input, 1: rising-edge clock shared with IROM/IRAM.
- `reset_n` input, 1: asynchronous, active-low reset.
- `cmd` input, 3: command code.
- `cmd_valid` input, 1: command strobe, sampled only while `busy`=0.
- `IROM_Q` input, `PIX_W`: ROM read data.
- `IROM_EN` output, 1: ROM chip enable, active-low (drives `CEN`).
- `IROM_A` output, `ADDR_W`: ROM address.
- `busy` output, 1: controller not accepting commands.
- `done` output, 1: one-cycle pulse at the end of a frame write.
- `IRAM_valid` output, 1: `IRAM_D`/`IRAM_A` valid this cycle.
- `IRAM_D` output, `PIX_W`: pixel write data.
- `IRAM_A` output, `ADDR_W`: pixel write address.

## Operation
- Pixel index = row*8 + col. Operation point (px,py) resets to (4,4); legal range is 2..6 on each axis. Window = rows py-2..py+1, cols px-2..px+1.
- Command codes: 0 WRITE, 1 SHIFT_UP (py-1), 2 SHIFT_DOWN (py+1), 3 SHIFT_LEFT (px-1), 4 SHIFT_RIGHT (px+1), 5 AVERAGE, 6 MIRROR_X, 7 MIRROR_Y.
- State machine states: LOAD, IDLE, EXEC, AVG, WRITE.
  - LOAD → IDLE after pixel 63 is stored.
  - IDLE → EXEC on `cmd_valid`, latching `cmd`.
  - EXEC → AVG for cmd 5, → WRITE for cmd 0, otherwise → IDLE.
  - AVG → IDLE after the window write-back.
  - WRITE → IDLE after `done`.
- LOAD: `IROM_EN`=0 while `IROM_A` walks 0..63, one address per cycle. Each `IROM_Q` is captured one cycle after its address is sampled by the ROM. `IROM_EN` returns to 1 after A=63 has been sampled.
- Shift commands: saturate. A shift past 2 or 6 leaves the point unchanged; it is still a legal command with the same busy timing.
- AVERAGE: accumulate the 16 window pixels over 16 cycles into a 12-bit sum. Result = sum>>4 (floor). In the 17th cycle all 16 window pixels are written with the result.
- MIRROR_X: swap window rows top↔bottom. MIRROR_Y: swap window columns left↔right. Each is a single-cycle buffer update.
- WRITE: 64 consecutive cycles with `IRAM_valid`=1 and `IRAM_A`=0..63, `IRAM_D`=buffer[IRAM_A]. `done`=1 in the cycle after A=63. Buffer and point are unchanged.
- `cmd_valid` while `busy`=1 is ignored. No queuing.

## Timing
- Reset values: `busy`=1, `done`=0, `IROM_EN`=1, `IROM_A`=0, `IRAM_valid`=0, `IRAM_D`=0, `IRAM_A`=0, point=(4,4), buffer=0.
- All outputs are registered.
- LOAD completes and `busy` falls no later than 67 cycles after `reset_n` deasserts.
- `busy` rises the cycle after an accepted `cmd_valid`. Busy duration:
  - shift/mirror: 1 cycle.
  - AVERAGE: 18 cycles.
  - WRITE: 66 cycles (64 data + `done` + return).
- `busy` falls in the same cycle the FSM enters IDLE. A new command is accepted at that edge.
- `reset_n` asserted mid-operation returns the controller to LOAD and reloads the full frame. Any partial IRAM stream is abandoned with `IRAM_valid` forced to 0.

## Configuration
- `LCD_CTRL_MIRROR_EN` defined: cmds 6/7 perform the mirrors as above.
- Undefined: no mirror logic is instantiated. Cmds 6/7 are no-ops with 1-cycle busy; buffer is unchanged.

## Structure
- Package `lcd_ctrl_pkg`: command code constants, FSM state encoding, `PT_MIN`=2, `PT_MAX`=6, `PT_RST`=4, window size 4.
- Sub-module `lcd_win_avg`: 16-cycle accumulator with clear/accumulate/result ports, 12-bit sum and floor-divide output.
- Top module holds the 64×8 buffer, FSM, point registers and the mirror muxing.

## Test plan
- Reset release with ROM mem[a]=a → `IROM_A` 0..63 with `IROM_EN`=0, `busy` falls ≤67 cycles; then WRITE → IRAM receives D=A for A=0..63, one `done` pulse.
- AVERAGE at (4,4) with mem[a]=a → window sum 504, result 31. WRITE shows addresses 18..21, 26..29, 34..37, 42..45 = 31; all others unchanged.
- SHIFT_RIGHT ×3 from (4,4) → point saturates at (6,4). AVERAGE then affects cols 4..7 only; busy is 1 cycle per shift.
- MIRROR_X at (4,4) with mem[a]=a, then WRITE → IRAM[18]=42, IRAM[42]=18, IRAM[26]=34. Without `LCD_CTRL_MIRROR_EN` → IRAM[18]=18.
- `cmd_valid` pulsed during AVERAGE busy → ignored; buffer and point match the single-command result.
- `reset_n` low at WRITE address 20 → `IRAM_valid` drops immediately; after release, LOAD repeats and point = (4,4).
